// File: rtl/riscv_gdb_rsp_rx.sv
// GDB Remote Serial Protocol receive engine: deframes $payload#cs, checks the mod-256 sum,
// un-escapes into a payload buffer and replies +/-. Define RISCV_GDB_RSP_RLE_EN for '*' run-length expansion.
module riscv_gdb_rsp_rx #(
    parameter int BUF_DEPTH = 512,
    parameter int AW        = $clog2(BUF_DEPTH),
    parameter int LW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_vld,
    input  logic [7:0]    rx_dat,
    output logic          rx_rdy,
    output logic          tx_vld,
    output logic [7:0]    tx_dat,
    input  logic          tx_rdy,
    input  logic          noack,
    output logic          pkt_vld,
    input  logic          pkt_rdy,
    output logic [7:0]    pkt_cmd,
    output logic [LW-1:0] pkt_len,
    input  logic [AW-1:0] buf_adr,
    output logic [7:0]    buf_dat,
    output logic          brk,
    output logic          ack_rcv,
    output logic          nak_rcv,
    output logic          err_chk,
    output logic          err_ovf
);

    typedef enum logic [2:0] {
        IDLE, DATA, ESC, CS_HI, CS_LO, ACK, HOLD
`ifdef RISCV_GDB_RSP_RLE_EN
        , RLE
`endif
    } state_t;

    localparam logic [LW-1:0] DEPTH_L = LW'(BUF_DEPTH);

    // {valid, nibble} for an ASCII hex digit
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    sum_q, sum_d;
    logic [LW-1:0] len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          bad_q, bad_d;
    logic [3:0]    cs_hi_q, cs_hi_d;
    logic          good_q, good_d;
    logic [7:0]    tx_dat_q, tx_dat_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    buf_dat_q, buf_dat_d;
    logic          brk_q, brk_d;
    logic          ack_rcv_q, ack_rcv_d;
    logic          nak_rcv_q, nak_rcv_d;
    logic          err_chk_q, err_chk_d;
    logic          err_ovf_q, err_ovf_d;
    logic [7:0]    mem_q [BUF_DEPTH];
`ifdef RISCV_GDB_RSP_RLE_EN
    logic [7:0]    last_q, last_d;
    logic [7:0]    rpt_q, rpt_d;
    logic          star_q, star_d;
    logic          rle_err_q, rle_err_d;
`endif

    logic       rx_acc;
    logic       restart;
    logic       st_en;
    logic [7:0] st_dat;
    logic       wr_en;
    logic [4:0] nib;
    logic       chk_bad;
    logic       pkt_good;

    assign rx_rdy  = (state_q == IDLE) || (state_q == DATA) || (state_q == ESC) ||
                     (state_q == CS_HI) || (state_q == CS_LO);
    assign rx_acc  = rx_vld & rx_rdy;
    assign tx_vld  = (state_q == ACK);
    assign tx_dat  = tx_dat_q;
    assign pkt_vld = (state_q == HOLD);
    assign pkt_cmd = cmd_q;
    assign pkt_len = len_q;
    assign buf_dat = buf_dat_q;
    assign brk     = brk_q;
    assign ack_rcv = ack_rcv_q;
    assign nak_rcv = nak_rcv_q;
    assign err_chk = err_chk_q;
    assign err_ovf = err_ovf_q;

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        bad_d     = bad_q;
        cs_hi_d   = cs_hi_q;
        good_d    = good_q;
        tx_dat_d  = tx_dat_q;
        cmd_d     = cmd_q;
        brk_d     = 1'b0;
        ack_rcv_d = 1'b0;
        nak_rcv_d = 1'b0;
        err_chk_d = 1'b0;
        err_ovf_d = 1'b0;
        restart   = 1'b0;
        st_en     = 1'b0;
        st_dat    = rx_dat;
        wr_en     = 1'b0;
        nib       = hex_nib(rx_dat);
        chk_bad   = 1'b0;
        pkt_good  = 1'b0;
        buf_dat_d = mem_q[buf_adr];
`ifdef RISCV_GDB_RSP_RLE_EN
        last_d    = last_q;
        rpt_d     = rpt_q;
        star_d    = star_q;
        rle_err_d = rle_err_q;
`endif
        case (state_q)
            IDLE: if (rx_acc) begin
                case (rx_dat)
                    8'h24:   restart   = 1'b1;
                    8'h03:   brk_d     = 1'b1;
                    8'h2B:   ack_rcv_d = 1'b1;
                    8'h2D:   nak_rcv_d = 1'b1;
                    default: ;
                endcase
            end
            DATA: if (rx_acc) begin
                if (rx_dat == 8'h24)
                    restart = 1'b1;
`ifdef RISCV_GDB_RSP_RLE_EN
                else if (star_q) begin
                    // count byte: repeat the last stored byte (n-29) times
                    sum_d  = sum_q + rx_dat;
                    star_d = 1'b0;
                    if (rx_dat < 8'h20 || len_q == '0)
                        rle_err_d = 1'b1;
                    else begin
                        rpt_d   = rx_dat - 8'd29;
                        state_d = RLE;
                    end
                end
`endif
                else if (rx_dat == 8'h23)
                    state_d = CS_HI;
                else if (rx_dat == 8'h7D) begin
                    sum_d   = sum_q + rx_dat;
                    state_d = ESC;
                end
`ifdef RISCV_GDB_RSP_RLE_EN
                else if (rx_dat == 8'h2A) begin
                    sum_d  = sum_q + rx_dat;
                    star_d = 1'b1;
                end
`endif
                else begin
                    sum_d = sum_q + rx_dat;
                    st_en = 1'b1;
                end
            end
            ESC: if (rx_acc) begin
                sum_d   = sum_q + rx_dat;
                st_en   = 1'b1;
                st_dat  = rx_dat ^ 8'h20;
                state_d = DATA;
            end
            CS_HI: if (rx_acc) begin
                cs_hi_d = nib[3:0];
                bad_d   = bad_q | ~nib[4];
                state_d = CS_LO;
            end
            CS_LO: if (rx_acc) begin
                chk_bad = bad_q | ~nib[4] | ({cs_hi_q, nib[3:0]} != sum_q);
`ifdef RISCV_GDB_RSP_RLE_EN
                chk_bad = chk_bad | rle_err_q | star_q;
`endif
                pkt_good  = ~ovf_q & ~chk_bad;
                err_ovf_d = ovf_q;
                err_chk_d = ~ovf_q & chk_bad;
                good_d    = pkt_good;
                tx_dat_d  = pkt_good ? 8'h2B : 8'h2D;
                if (noack)
                    state_d = pkt_good ? HOLD : IDLE;
                else
                    state_d = ACK;
            end
            ACK:  if (tx_rdy)  state_d = good_q ? HOLD : IDLE;
            HOLD: if (pkt_rdy) state_d = IDLE;
`ifdef RISCV_GDB_RSP_RLE_EN
            RLE: begin
                st_en  = 1'b1;
                st_dat = last_q;
                rpt_d  = rpt_q - 8'd1;
                if (rpt_q == 8'd1)
                    state_d = DATA;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d = DATA;
            sum_d   = 8'h00;
            len_d   = '0;
            ovf_d   = 1'b0;
            bad_d   = 1'b0;
            cmd_d   = 8'h00;
`ifdef RISCV_GDB_RSP_RLE_EN
            star_d    = 1'b0;
            rle_err_d = 1'b0;
`endif
        end

        // length saturates at BUF_DEPTH; bytes beyond it only raise the overflow flag
        if (st_en) begin
            if (len_q < DEPTH_L) begin
                wr_en = 1'b1;
                len_d = len_q + 1'b1;
                if (len_q == '0)
                    cmd_d = st_dat;
            end else
                ovf_d = 1'b1;
`ifdef RISCV_GDB_RSP_RLE_EN
            last_d = st_dat;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sum_q     <= 8'h00;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
            cs_hi_q   <= 4'h0;
            good_q    <= 1'b0;
            tx_dat_q  <= 8'h00;
            cmd_q     <= 8'h00;
            buf_dat_q <= 8'h00;
            brk_q     <= 1'b0;
            ack_rcv_q <= 1'b0;
            nak_rcv_q <= 1'b0;
            err_chk_q <= 1'b0;
            err_ovf_q <= 1'b0;
`ifdef RISCV_GDB_RSP_RLE_EN
            last_q    <= 8'h00;
            rpt_q     <= 8'h00;
            star_q    <= 1'b0;
            rle_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
            cs_hi_q   <= cs_hi_d;
            good_q    <= good_d;
            tx_dat_q  <= tx_dat_d;
            cmd_q     <= cmd_d;
            buf_dat_q <= buf_dat_d;
            brk_q     <= brk_d;
            ack_rcv_q <= ack_rcv_d;
            nak_rcv_q <= nak_rcv_d;
            err_chk_q <= err_chk_d;
            err_ovf_q <= err_ovf_d;
`ifdef RISCV_GDB_RSP_RLE_EN
            last_q    <= last_d;
            rpt_q     <= rpt_d;
            star_q    <= star_d;
            rle_err_q <= rle_err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[len_q[AW-1:0]] <= st_dat;
    end

endmodule

// File: tb/tb_riscv_gdb_rsp_rx.sv
// Directed, table-driven bench for riscv_gdb_rsp_rx (default build, 4-byte buffer).
module tb_riscv_gdb_rsp_rx;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_vld = 1'b0;
    logic [7:0]    rx_dat = 8'h00;
    logic          rx_rdy;
    logic          tx_vld;
    logic [7:0]    tx_dat;
    logic          tx_rdy = 1'b1;
    logic          noack = 1'b0;
    logic          pkt_vld;
    logic          pkt_rdy = 1'b0;
    logic [7:0]    pkt_cmd;
    logic [LW-1:0] pkt_len;
    logic [AW-1:0] buf_adr = '0;
    logic [7:0]    buf_dat;
    logic          brk, ack_rcv, nak_rcv, err_chk, err_ovf;

    riscv_gdb_rsp_rx #(.BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
        .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rdy(tx_rdy),
        .noack(noack),
        .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
        .buf_adr(buf_adr), .buf_dat(buf_dat),
        .brk(brk), .ack_rcv(ack_rcv), .nak_rcv(nak_rcv),
        .err_chk(err_chk), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // event counters sampled on the falling edge
    int         n_tx, n_brk, n_ack, n_nak, n_chk, n_ovf, n_pkt;
    logic [7:0] last_tx = 8'h00;
    logic       pkt_prev = 1'b0;
    always @(negedge clk) begin
        if (tx_vld && tx_rdy) begin n_tx++; last_tx = tx_dat; end
        if (brk)     n_brk++;
        if (ack_rcv) n_ack++;
        if (nak_rcv) n_nak++;
        if (err_chk) n_chk++;
        if (err_ovf) n_ovf++;
        if (pkt_vld && !pkt_prev) n_pkt++;
        pkt_prev = pkt_vld;
    end

    int b_tx, b_brk, b_ack, b_nak, b_chk, b_ovf, b_pkt;
    task automatic snap();
        b_tx = n_tx; b_brk = n_brk; b_ack = n_ack; b_nak = n_nak;
        b_chk = n_chk; b_ovf = n_ovf; b_pkt = n_pkt;
    endtask

    int n_vec = 0;
    int n_mis = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_vld = 1'b1;
        rx_dat = b;
        while (!rx_rdy && n < 50) begin tick(); n++; end
        if (!rx_rdy) chk("rx_rdy_timeout", 32'd0, 32'd1);
        else tick();
        rx_vld = 1'b0;
    endtask

    task automatic send_str(input logic [127:0] p, input int n);
        for (int k = 0; k < n; k++) send_byte(p[(n-1-k)*8 +: 8]);
    endtask

    typedef struct packed {
        logic [127:0] pkt;
        logic [7:0]   n;
        logic         noack;
        logic [8:0]   tx;     // bit 8 set: a reply byte is expected
        logic         vld;
        logic [7:0]   cmd;
        logic [7:0]   len;
        logic [31:0]  bytes;  // buf[0] in [31:24]
        logic [4:0]   ev;     // {brk, ack_rcv, nak_rcv, err_chk, err_ovf}
    } vec_t;

    function automatic vec_t mk(input logic [127:0] p, input int n, input bit na, input int tx,
                                input bit vld, input logic [7:0] cmd, input int len,
                                input logic [31:0] b, input logic [4:0] ev);
        vec_t r;
        r.pkt = p; r.n = 8'(n); r.noack = na;
        r.tx = (tx < 0) ? 9'h000 : {1'b1, 8'(tx)};
        r.vld = vld; r.cmd = cmd; r.len = 8'(len); r.bytes = b; r.ev = ev;
        return r;
    endfunction

    localparam int NV = 18;
    vec_t v [NV];

    initial begin
        v[0]  = mk("$g#67",     5, 0, 'h2B, 1, 8'h67, 1, 32'h67000000, 5'b00000);
        v[1]  = mk("$m0,4#fd",  8, 0, 'h2B, 1, 8'h6D, 4, 32'h6D302C34, 5'b00000);
        v[2]  = mk("$m0,4#FD",  8, 0, 'h2B, 1, 8'h6D, 4, 32'h6D302C34, 5'b00000);
        v[3]  = mk("$g#68",     5, 0, 'h2D, 0, 8'h00, 0, 32'h0,        5'b00010);
        v[4]  = mk("$#00",      4, 0, 'h2B, 1, 8'h00, 0, 32'h0,        5'b00000);
        v[5]  = mk("$}##a0",    6, 0, 'h2B, 1, 8'h03, 1, 32'h03000000, 5'b00000);
        v[6]  = mk("\003",      1, 0, -1,   0, 8'h00, 0, 32'h0,        5'b10000);
        v[7]  = mk("+",         1, 0, -1,   0, 8'h00, 0, 32'h0,        5'b01000);
        v[8]  = mk("-",         1, 0, -1,   0, 8'h00, 0, 32'h0,        5'b00100);
        v[9]  = mk("$abcde#ff", 9, 0, 'h2D, 0, 8'h00, 0, 32'h0,        5'b00001);
        v[10] = mk("$g#67",     5, 1, -1,   1, 8'h67, 1, 32'h67000000, 5'b00000);
        v[11] = mk("$g#zz",     5, 0, 'h2D, 0, 8'h00, 0, 32'h0,        5'b00010);
        v[12] = mk("x$g#67",    6, 0, 'h2B, 1, 8'h67, 1, 32'h67000000, 5'b00000);
        v[13] = mk("$ab$g#67",  8, 0, 'h2B, 1, 8'h67, 1, 32'h67000000, 5'b00000);
        v[14] = mk("$abcd#8a",  8, 0, 'h2B, 1, 8'h61, 4, 32'h61626364, 5'b00000);
        v[15] = mk("$g#6z",     5, 0, 'h2D, 0, 8'h00, 0, 32'h0,        5'b00010);
        v[16] = mk("$\003#03",  5, 0, 'h2B, 1, 8'h03, 1, 32'h03000000, 5'b00000);
        v[17] = mk("$a*#8b",    6, 0, 'h2B, 1, 8'h61, 2, 32'h612A0000, 5'b00000);

        // reset state
        repeat (2) tick();
        rst = 1'b0;
        chk("rst.rx_rdy",  32'(rx_rdy),  32'd1);
        chk("rst.tx_vld",  32'(tx_vld),  32'd0);
        chk("rst.pkt_vld", 32'(pkt_vld), 32'd0);
        chk("rst.buf_dat", 32'(buf_dat), 32'd0);
        chk("rst.pkt_len", 32'(pkt_len), 32'd0);
        chk("rst.pulses",  32'({brk, ack_rcv, nak_rcv, err_chk, err_ovf}), 32'd0);

        for (int i = 0; i < NV; i++) begin
            noack = v[i].noack;
            snap();
            send_str(v[i].pkt, int'(v[i].n));
            repeat (6) tick();
            noack = 1'b0;
            chk($sformatf("v%0d.tx_cnt", i), 32'(n_tx - b_tx), 32'(v[i].tx[8]));
            if (v[i].tx[8]) chk($sformatf("v%0d.tx_dat", i), 32'(last_tx), 32'(v[i].tx[7:0]));
            chk($sformatf("v%0d.brk", i),     32'(n_brk - b_brk), 32'(v[i].ev[4]));
            chk($sformatf("v%0d.ack_rcv", i), 32'(n_ack - b_ack), 32'(v[i].ev[3]));
            chk($sformatf("v%0d.nak_rcv", i), 32'(n_nak - b_nak), 32'(v[i].ev[2]));
            chk($sformatf("v%0d.err_chk", i), 32'(n_chk - b_chk), 32'(v[i].ev[1]));
            chk($sformatf("v%0d.err_ovf", i), 32'(n_ovf - b_ovf), 32'(v[i].ev[0]));
            chk($sformatf("v%0d.pkt_cnt", i), 32'(n_pkt - b_pkt), 32'(v[i].vld));
            chk($sformatf("v%0d.pkt_vld", i), 32'(pkt_vld), 32'(v[i].vld));
            if (v[i].vld) begin
                chk($sformatf("v%0d.pkt_cmd", i), 32'(pkt_cmd), 32'(v[i].cmd));
                chk($sformatf("v%0d.pkt_len", i), 32'(pkt_len), 32'(v[i].len));
                for (int j = 0; j < int'(v[i].len); j++) begin
                    buf_adr = AW'(j);
                    tick();
                    chk($sformatf("v%0d.buf%0d", i, j), 32'(buf_dat), 32'(v[i].bytes[(3-j)*8 +: 8]));
                end
                pkt_rdy = 1'b1;
                tick();
                pkt_rdy = 1'b0;
                chk($sformatf("v%0d.pkt_vld_drop", i), 32'(pkt_vld), 32'd0);
                chk($sformatf("v%0d.rx_rdy_idle", i), 32'(rx_rdy), 32'd1);
            end
        end

        // ack back-pressure: tx_dat holds until tx_rdy, pkt_vld one cycle after the handshake
        tx_rdy = 1'b0;
        send_str("$g#67", 5);
        tick();
        chk("bp.tx_vld", 32'(tx_vld), 32'd1);
        chk("bp.tx_dat1", 32'(tx_dat), 32'h2B);
        repeat (2) tick();
        chk("bp.tx_dat3", 32'(tx_dat), 32'h2B);
        chk("bp.rx_rdy", 32'(rx_rdy), 32'd0);
        chk("bp.pkt_vld_wait", 32'(pkt_vld), 32'd0);
        tx_rdy = 1'b1;
        tick();
        chk("bp.pkt_vld_lat", 32'(pkt_vld), 32'd1);
        chk("bp.tx_vld_off", 32'(tx_vld), 32'd0);
        pkt_rdy = 1'b1;
        tick();
        pkt_rdy = 1'b0;
        chk("bp.pkt_vld_drop", 32'(pkt_vld), 32'd0);

        // noack: pkt_vld one cycle after CS_LO, pkt_rdy already high accepts it immediately
        noack = 1'b1;
        pkt_rdy = 1'b1;
        snap();
        send_str("$g#67", 5);
        chk("na.pkt_vld", 32'(pkt_vld), 32'd1);
        tick();
        chk("na.pkt_vld_1cyc", 32'(pkt_vld), 32'd0);
        chk("na.no_tx", 32'(n_tx - b_tx), 32'd0);
        pkt_rdy = 1'b0;

        // noack: held packet stalls the next '$' until pkt_rdy
        send_str("$g#67", 5);
        chk("st.pkt_vld", 32'(pkt_vld), 32'd1);
        rx_vld = 1'b1;
        rx_dat = 8'h24;
        repeat (3) begin
            tick();
            chk("st.rx_rdy_stall", 32'(rx_rdy), 32'd0);
        end
        chk("st.pkt_vld_hold", 32'(pkt_vld), 32'd1);
        pkt_rdy = 1'b1;
        tick();
        pkt_rdy = 1'b0;
        chk("st.pkt_vld_drop", 32'(pkt_vld), 32'd0);
        chk("st.rx_rdy", 32'(rx_rdy), 32'd1);
        tick();
        rx_vld = 1'b0;
        send_str("m#6d", 4);
        chk("st.pkt2_vld", 32'(pkt_vld), 32'd1);
        chk("st.pkt2_cmd", 32'(pkt_cmd), 32'h6D);
        pkt_rdy = 1'b1;
        tick();
        pkt_rdy = 1'b0;
        noack = 1'b0;

        // reset mid-payload: packet discarded, trailing bytes ignored in IDLE
        snap();
        send_str("$ab", 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr.rx_rdy", 32'(rx_rdy), 32'd1);
        chk("mr.pkt_len", 32'(pkt_len), 32'd0);
        send_str("#c3", 3);
        repeat (6) tick();
        chk("mr.no_tx", 32'(n_tx - b_tx), 32'd0);
        chk("mr.no_pkt", 32'(n_pkt - b_pkt), 32'd0);
        chk("mr.no_err", 32'((n_chk - b_chk) + (n_ovf - b_ovf)), 32'd0);
        chk("mr.pkt_vld", 32'(pkt_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/riscv_gdb_rsp_rx.md
Name: riscv_gdb_rsp_rx

Overview:
- Synthesizable GDB Remote Serial Protocol receive engine; the hardware successor to the testbench socket stub.
- Sits between a byte transport (UART/JTAG byte bridge) and the debug command executor.
- Deframes `$payload#cs`, verifies the mod-256 checksum, un-escapes payload into an internal buffer, and generates `+`/`-` acknowledges.
- Detects out-of-band break (0x03) and received acks; supports runtime no-ack mode (QStartNoAckMode).

Parameters:
- BUF_DEPTH, 512, payload buffer size in bytes (power of 2, >=4).
- AW, $clog2(BUF_DEPTH), buffer address width (derived, do not override).
- LW, $clog2(BUF_DEPTH+1), packet length width (derived).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rx_vld  input  1  incoming byte valid
- rx_dat  input  8  incoming byte
- rx_rdy  output  1  incoming byte ready; transfer on rx_vld&rx_rdy
- tx_vld  output  1  ack byte valid
- tx_dat  output  8  ack byte (`+`=0x2B, `-`=0x2D)
- tx_rdy  input  1  ack byte ready
- noack  input  1  no-ack mode; sampled when a packet completes
- pkt_vld  output  1  complete good packet available
- pkt_rdy  input  1  executor consumed packet
- pkt_cmd  output  8  first payload byte (0x00 if empty)
- pkt_len  output  LW  payload length after un-escape
- buf_adr  input  AW  payload read address
- buf_dat  output  8  payload byte; registered, 1-cycle read latency
- brk  output  1  1-cycle pulse: 0x03 received outside a packet
- ack_rcv  output  1  1-cycle pulse: `+` received outside a packet
- nak_rcv  output  1  1-cycle pulse: `-` received outside a packet
- err_chk  output  1  1-cycle pulse: checksum mismatch or non-hex checksum digit
- err_ovf  output  1  1-cycle pulse: payload exceeded BUF_DEPTH

Behaviour:
- Reset (sync, active-high): state=IDLE. All outputs 0 except rx_rdy=1 and buf_dat=0. In-flight packet discarded; buffer contents undefined.
- States: IDLE, DATA, ESC, CS_HI, CS_LO, ACK, HOLD (+ RLE when enabled).
- rx_rdy=1 in IDLE/DATA/ESC/CS_HI/CS_LO; rx_rdy=0 in ACK/HOLD.
- IDLE transitions:
  - `$`: clear sum and len, go to DATA.
  - 0x03: brk pulse.
  - `+`: ack_rcv pulse.
  - `-`: nak_rcv pulse.
  - Any other byte is silently dropped.
- DATA transitions:
  - `#`: go to CS_HI.
  - `$`: resync; restart the packet, clear sum and len.
  - 0x7D: sum+=byte, go to ESC.
  - Other byte: sum+=byte, store at buf[len] if len<BUF_DEPTH (else set ovf flag), len++ saturating at BUF_DEPTH.
- ESC: sum+=raw byte; store raw^0x20 (same overflow rule); return to DATA. `#` and `$` in ESC are data, not delimiters.
- Checksum: 8-bit sum of all raw bytes strictly between `$` and `#`, wrapping mod 256.
- CS_HI, CS_LO: each accepts one hex digit (0-9, a-f, A-F). A non-hex digit marks the checksum bad.
- After CS_LO the packet is evaluated (noack sampled in that cycle):
  - Overflow: err_ovf pulse, reply `-`, no pkt_vld. Overflow takes priority over checksum error.
  - Bad checksum: err_chk pulse, reply `-`, no pkt_vld.
  - Good: reply `+`, then assert pkt_vld.
  - With noack=1, no reply byte is sent and the engine goes directly to HOLD (good packet) or IDLE (bad packet).
- ACK: tx_vld=1 with tx_dat stable until tx_rdy. Then go to HOLD (good) or IDLE (bad).
- HOLD:
  - pkt_vld=1; pkt_cmd, pkt_len and buffer contents stable.
  - pkt_rdy accepted the same cycle pkt_vld rises.
  - On pkt_vld&pkt_rdy: go to IDLE; pkt_vld=0 next cycle.
  - buf_dat = buf[buf_adr] registered; valid in any state, meaningful in HOLD.
- Latency: pkt_vld asserts 1 cycle after the tx handshake, or 1 cycle after the CS_LO byte in noack mode.
- Simultaneous events: error pulses are single-cycle in the cycle after CS_LO acceptance. brk inside a packet is payload data, not a break.

Optional Feature:
- RISCV_GDB_RSP_RLE_EN
- Defined:
  - In DATA, `*` followed by count byte n (0x20..0x7E) repeats the previously stored byte (n-29) times.
  - Both bytes count toward sum.
  - Expansion writes 1 byte/cycle in state RLE with rx_rdy=0.
  - Overflow rule applies per written byte.
  - `*` as the first payload byte or n<0x20 sets err_chk at packet end.
- Undefined: `*` is stored literally like any byte.

Test Plan:
- `$g#67` (noack=0) -> tx `+`, then pkt_vld=1, pkt_cmd=0x67, pkt_len=1. Pulse pkt_rdy -> pkt_vld=0 next cycle.
- `$m0,4#fd` -> `+`, pkt_len=4, buf[0..3]=6D 30 2C 34 read with 1-cycle latency. Same packet with `#FD` -> identical result.
- `$g#68` -> tx `-`, err_chk pulse, pkt_vld stays 0. Then `$#00` -> `+`, pkt_len=0, pkt_cmd=0x00.
- `$`,7D,23,`#a0` -> `+`, pkt_len=1, buf[0]=0x03. Byte 0x03 in IDLE -> brk pulse, no tx. `+` in IDLE -> ack_rcv pulse.
- BUF_DEPTH=4, `$abcde#ff` -> tx `-`, err_ovf pulse, no err_chk, no pkt_vld.
- noack=1, `$g#67` -> no tx_vld, pkt_vld=1. With pkt_rdy=0, the next `$` stalls (rx_rdy=0) until pkt_rdy. Reset asserted mid-payload -> IDLE, all pulses 0, no pkt_vld.
